alu_seq_core: RTL and testbench
===============================

# alu_seq_core

Parametrised, handshaked successor to the master ALU: executes the same 4-bit opcode set on WIDTH-bit signed operands, holds NZCV in an internal flag register and gates execution on a 4-bit condition code. Multiply is iterative (shift-add, one bit per cycle); all other ops complete in one cycle. Sits between the decode/register-read stage and writeback.

## Interface
- WIDTH, 32: operand/result width; power of two ≥ 8
- IMM_W, 16: immediate (IV) width; ≤ WIDTH
- SHW, $clog2(WIDTH): shift-amount bits taken from IV[SHW-1:0]
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid / in_ready  in/out  1  request handshake
- op  in  4  opcode: 0000 ADD, 0001 SUB, 0010 MUL, 0011 OR, 0100 AND, 0101 XOR, 0110 MOVn, 0111 MOV, 1000 LSR, 1001 LSL, 1010 ROR, 1011 CMP, 1100–1111 NOP
- cond  in  4  0000 AL, 0001 EQ, 0010 NE, 0011 CS, 0100 CC, 0101 MI, 0110 PL, 0111 VS, 1000 VC, 1001 HI, 1010 LS, 1011 GE, 1100 LT, 1101 GT, 1110 LE, 1111 NV
- s  in  1  update flags when executed
- a, b  in  WIDTH  signed operands (Reg1, Reg2)
- iv  in  IMM_W  immediate
- out_valid / out_ready  out/in  1  result handshake
- result  out  WIDTH  registered result
- executed  out  1  condition passed for this result
- flags  out  4  flag register {N,Z,C,V}

## Operation
- States: IDLE, MUL_BUSY. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept on in_valid && in_ready. Condition evaluated against flag register at accept.
- Condition fails: result=0, executed=0, flags unchanged; single-cycle, including MUL.
- ADD/SUB: a±b; C = carry-out (SUB: C = no-borrow, i.e. a ≥ b unsigned); V = signed overflow.
- CMP: SUB flags, result=0, flags written regardless of s.
- OR/AND/XOR: a op b; C,V kept.
- MOVn: zero-extended iv; MOV: b; C,V kept.
- LSR/LSL/ROR: a shifted by iv[SHW-1:0]; C = last bit shifted out; amount 0 → result=a, C kept; V kept.
- MUL: low WIDTH bits of a*b (signed, two's-complement low half); N,Z set, C,V kept.
- NOP (incl. 1100–1110): result=0, flags unchanged, executed=1.
- N = result[WIDTH-1], Z = (result==0) for all flag-writing ops.
- Flag register and result register load on the same edge; flags written only if executed && (s || op==CMP).

## Timing
- Reset: state=IDLE, out_valid=0, result=0, executed=0, flags=0000, multiplier regs 0.
- Single-cycle ops: accepted at edge k → out_valid, result, flags valid after edge k.
- MUL: accepted at edge k enters MUL_BUSY; WIDTH iterations; out_valid after edge k+WIDTH. in_ready=0 throughout.
- Back-to-back: op accepted at edge k+1 sees flags written at edge k.
- out_valid held, result/flags stable until out_ready; next completion cannot overwrite pending result.
- Reset asserted in MUL_BUSY aborts the multiply; no out_valid produced.

## Configuration
- ALU_MUL_EN defined: iterative multiplier and MUL_BUSY state compiled in as above.
- ALU_MUL_EN undefined: MUL decodes as NOP (result=0, flags unchanged, single-cycle); no multiplier logic.

## Test plan
- ADD a=0x60000000, b=0x20000001, s=1, cond=AL → result 0x80000001, flags 1001, out_valid one cycle after accept.
- SUB a=5, b=7, s=1 → result 0xFFFFFFFE, flags 1000; then CMP a=7, b=7 → result 0, flags 0110.
- MUL a=7, b=7, s=1 (ALU_MUL_EN) → in_ready low WIDTH cycles, result 49, flags 0000 after edge k+32; without macro → result 0, flags unchanged, 1 cycle.
- Flags Z=0, issue MOV b=5 cond=EQ → executed=0, result 0, flags unchanged; cond=NE → result 5, executed=1.
- ROR a=5, iv=4 → result 0x50000000, C=0; LSL a=5, iv=5 → 0xA0; LSR a=0x60000001, iv=1 → 0x30000000, C=1.
- out_ready held low 3 cycles after ADD → result stable, in_ready low; reset mid-MUL → out_valid 0, flags 0000, in_ready 1 after release.

Source files
------------

// File: rtl/alu_seq_core.sv
// alu_seq_core: handshaked WIDTH-bit ALU with NZCV flag register and condition gating.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (MUL_BUSY state).
module alu_seq_core #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [3:0]       cond,
    input  logic             s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [IMM_W-1:0] iv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             executed,
    output logic [3:0]       flags
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_MOVN = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_LSR  = 4'h8;
    localparam logic [3:0] OP_LSL  = 4'h9;
    localparam logic [3:0] OP_ROR  = 4'hA;
    localparam logic [3:0] OP_CMP  = 4'hB;

    typedef enum logic [0:0] {
        IDLE,
        MUL_BUSY
    } state_t;

    state_t             state_q;
    logic               ov_q;
    logic [WIDTH-1:0]   res_q;
    logic               exe_q;
    logic [3:0]         flg_q;

    logic               accept;
    logic               cond_ok;
    logic               mul_go;
    logic               n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flg_q;
    assign in_ready  = (state_q == IDLE) && (!ov_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = ov_q;
    assign result    = res_q;
    assign executed  = exe_q;
    assign flags     = flg_q;

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'h0:    cond_ok = 1'b1;
            4'h1:    cond_ok = z_f;
            4'h2:    cond_ok = !z_f;
            4'h3:    cond_ok = c_f;
            4'h4:    cond_ok = !c_f;
            4'h5:    cond_ok = n_f;
            4'h6:    cond_ok = !n_f;
            4'h7:    cond_ok = v_f;
            4'h8:    cond_ok = !v_f;
            4'h9:    cond_ok = c_f && !z_f;
            4'hA:    cond_ok = !c_f || z_f;
            4'hB:    cond_ok = (n_f == v_f);
            4'hC:    cond_ok = (n_f != v_f);
            4'hD:    cond_ok = !z_f && (n_f == v_f);
            4'hE:    cond_ok = z_f || (n_f != v_f);
            default: cond_ok = 1'b0;
        endcase
    end

    logic [WIDTH:0]   add_w, sub_w;
    logic             add_v, sub_v;
    logic [SHW-1:0]   sh, shm1, shl;
    logic [WIDTH-1:0] lsr_w, lsl_w, ror_w;

    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign add_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
    assign sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);

    // shl = WIDTH - sh (mod WIDTH): index of the last bit LSL drops
    assign sh    = iv[SHW-1:0];
    assign shm1  = sh - {{(SHW-1){1'b0}}, 1'b1};
    assign shl   = {SHW{1'b0}} - sh;
    assign lsr_w = a >> sh;
    assign lsl_w = a << sh;
    assign ror_w = lsr_w | (a << shl);

    logic [WIDTH-1:0] alu_d;
    logic [WIDTH-1:0] alu_res;
    logic             c_nx, v_nx, wr_nz, flag_we;
    logic [3:0]       alu_flags;

    always_comb begin
        alu_d = '0;
        c_nx  = c_f;
        v_nx  = v_f;
        wr_nz = 1'b1;
        case (op)
            OP_ADD: begin
                alu_d = add_w[WIDTH-1:0];
                c_nx  = add_w[WIDTH];
                v_nx  = add_v;
            end
            OP_SUB, OP_CMP: begin
                alu_d = sub_w[WIDTH-1:0];
                c_nx  = sub_w[WIDTH];
                v_nx  = sub_v;
            end
            OP_OR:   alu_d = a | b;
            OP_AND:  alu_d = a & b;
            OP_XOR:  alu_d = a ^ b;
            OP_MOVN: alu_d = WIDTH'(iv);
            OP_MOV:  alu_d = b;
            OP_LSR: begin
                alu_d = a;
                if (sh != '0) begin
                    alu_d = lsr_w;
                    c_nx  = a[shm1];
                end
            end
            OP_LSL: begin
                alu_d = a;
                if (sh != '0) begin
                    alu_d = lsl_w;
                    c_nx  = a[shl];
                end
            end
            OP_ROR: begin
                alu_d = a;
                if (sh != '0) begin
                    alu_d = ror_w;
                    c_nx  = a[shm1];
                end
            end
            default: wr_nz = 1'b0;
        endcase
        alu_res   = (op == OP_CMP || !cond_ok) ? '0 : alu_d;
        flag_we   = cond_ok && wr_nz && (s || op == OP_CMP);
        alu_flags = {alu_d[WIDTH-1], alu_d == '0, c_nx, v_nx};
    end

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_nx;
    logic [SHW-1:0]   cnt_q;
    logic             ms_q;
    logic             mul_last;

    assign mul_go   = accept && cond_ok && (op == OP_MUL);
    assign acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last = (cnt_q == '1);

    // Only the low WIDTH product bits are kept, so unsigned shift-add is exact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            ms_q     <= 1'b0;
        end else if (mul_go) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            ms_q     <= s;
        end else if (state_q == MUL_BUSY) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_nx;
            cnt_q    <= cnt_q + {{(SHW-1){1'b0}}, 1'b1};
        end
    end
`else
    assign mul_go = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ov_q    <= 1'b0;
            res_q   <= '0;
            exe_q   <= 1'b0;
            flg_q   <= 4'b0000;
        end else begin
            if (ov_q && out_ready) ov_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mul_go) begin
                        state_q <= MUL_BUSY;
                    end else if (accept) begin
                        ov_q  <= 1'b1;
                        res_q <= alu_res;
                        exe_q <= cond_ok;
                        if (flag_we) flg_q <= alu_flags;
                    end
                end
`ifdef ALU_MUL_EN
                MUL_BUSY: begin
                    if (mul_last) begin
                        state_q <= IDLE;
                        ov_q    <= 1'b1;
                        res_q   <= acc_nx;
                        exe_q   <= 1'b1;
                        if (ms_q)
                            flg_q <= {acc_nx[WIDTH-1], acc_nx == '0, flg_q[1:0]};
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed and randomized checks of alu_seq_core against a
// behavioural arithmetic model of the opcode/condition/flag rules.
module tb_alu_seq_core;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    op = '0;
    logic [3:0]    cond = '0;
    logic          s = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [15:0]   iv = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic          executed;
    logic [3:0]    flags;

    logic [3:0]    mflags = 4'b0000;
    int            n_tests = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    alu_seq_core #(
        .WIDTH(W),
        .IMM_W(16),
        .SHW  (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .cond     (cond),
        .s        (s),
        .a        (a),
        .b        (b),
        .iv       (iv),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .executed (executed),
        .flags    (flags)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [3:0] o, input logic [3:0] c,
                         input logic sv, input logic [31:0] av,
                         input logic [31:0] bv, input logic [15:0] ivv,
                         output logic [31:0] r, output logic ex,
                         output logic [3:0] f, output int lat);
        logic n, z, cf, vf, wr;
        logic [63:0] ua, ub, t;
        logic [31:0] d;
        longint sa, sb, sr;
        int amt;
        {n, z, cf, vf} = mflags;
        ua  = {32'b0, av};
        ub  = {32'b0, bv};
        sa  = longint'($signed(av));
        sb  = longint'($signed(bv));
        amt = int'(ivv[4:0]);
        d   = '0;
        wr  = 1'b1;
        lat = 0;
        case (c)
            4'd0:    ex = 1'b1;
            4'd1:    ex = z;
            4'd2:    ex = !z;
            4'd3:    ex = cf;
            4'd4:    ex = !cf;
            4'd5:    ex = n;
            4'd6:    ex = !n;
            4'd7:    ex = vf;
            4'd8:    ex = !vf;
            4'd9:    ex = cf && !z;
            4'd10:   ex = !cf || z;
            4'd11:   ex = (n == vf);
            4'd12:   ex = (n != vf);
            4'd13:   ex = !z && (n == vf);
            4'd14:   ex = z || (n != vf);
            default: ex = 1'b0;
        endcase
        if (ex) begin
            case (o)
                4'd0: begin
                    t  = ua + ub;
                    d  = t[31:0];
                    cf = t[32];
                    sr = sa + sb;
                    vf = (sr != longint'($signed(d)));
                end
                4'd1, 4'd11: begin
                    d  = av - bv;
                    cf = (ua >= ub);
                    sr = sa - sb;
                    vf = (sr != longint'($signed(d)));
                end
                4'd2: begin
`ifdef ALU_MUL_EN
                    sr  = sa * sb;
                    d   = sr[31:0];
                    lat = W;
`else
                    wr  = 1'b0;
`endif
                end
                4'd3: d = av | bv;
                4'd4: d = av & bv;
                4'd5: d = av ^ bv;
                4'd6: d = {16'b0, ivv};
                4'd7: d = bv;
                4'd8: begin
                    d = av;
                    if (amt != 0) begin
                        t  = ua >> amt;
                        d  = t[31:0];
                        t  = ua >> (amt - 1);
                        cf = t[0];
                    end
                end
                4'd9: begin
                    d = av;
                    if (amt != 0) begin
                        t  = ua << amt;
                        d  = t[31:0];
                        cf = t[32];
                    end
                end
                4'd10: begin
                    d = av;
                    if (amt != 0) begin
                        t  = (ua >> amt) | (ua << (32 - amt));
                        d  = t[31:0];
                        cf = d[31];
                    end
                end
                default: wr = 1'b0;
            endcase
        end
        r = (o == 4'd11 || !ex) ? 32'd0 : d;
        if (ex && wr && (sv || o == 4'd11))
            f = {d[31], d == 32'd0, cf, vf};
        else
            f = mflags;
    endtask

    task automatic issue(input logic [3:0] o, input logic [3:0] c,
                         input logic sv, input logic [31:0] av,
                         input logic [31:0] bv, input logic [15:0] ivv);
        logic [31:0] er;
        logic        ee;
        logic [3:0]  ef;
        int          el, cyc, w;
        logic        rdy_seen;
        model(o, c, sv, av, bv, ivv, er, ee, ef, el);
        @(negedge clk);
        op = o; cond = c; s = sv; a = av; b = bv; iv = ivv;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("in_ready op%0d", o), in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        rdy_seen = 1'b0;
        while (!out_valid && cyc < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        check($sformatf("latency op%0d", o), cyc, el);
        if (el > 0) check("busy in_ready", rdy_seen, 0);
        check($sformatf("result op%0d c%0d", o, c), result, er);
        check($sformatf("executed op%0d c%0d", o, c), executed, ee);
        check($sformatf("flags op%0d c%0d", o, c), flags, ef);
        mflags = ef;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        check("rst out_valid", out_valid, 0);
        check("rst result", result, 0);
        check("rst executed", executed, 0);
        check("rst flags", flags, 0);
        check("rst in_ready", in_ready, 1);
        rst_n = 1'b1;

        issue(4'd2, 4'd0, 1'b1, 32'd7, 32'd7, 16'd0);
`ifdef ALU_MUL_EN
        check("mul lit", result, 32'd49);
`else
        check("mul nop", result, 32'd0);
`endif
        check("mul flags", flags, 4'b0000);

        issue(4'd0, 4'd0, 1'b1, 32'h6000_0000, 32'h2000_0001, 16'd0);
        check("add lit", result, 32'h8000_0001);
        check("add flags", flags, 4'b1001);
        issue(4'd1, 4'd0, 1'b1, 32'd5, 32'd7, 16'd0);
        check("sub lit", result, 32'hFFFF_FFFE);
        check("sub flags", flags, 4'b1000);
        issue(4'd11, 4'd0, 1'b0, 32'd7, 32'd7, 16'd0);
        check("cmp flags", flags, 4'b0110);

        issue(4'd7, 4'd0, 1'b1, 32'd0, 32'd5, 16'd0);
        issue(4'd7, 4'd1, 1'b0, 32'd0, 32'd5, 16'd0);
        check("eq skip", executed, 0);
        issue(4'd7, 4'd2, 1'b0, 32'd0, 32'd5, 16'd0);
        check("ne exec", result, 32'd5);

        issue(4'd10, 4'd0, 1'b1, 32'd5, 32'd0, 16'd4);
        check("ror lit", result, 32'h5000_0000);
        check("ror c", flags[1], 0);
        issue(4'd9, 4'd0, 1'b1, 32'd5, 32'd0, 16'd5);
        check("lsl lit", result, 32'hA0);
        issue(4'd8, 4'd0, 1'b1, 32'h6000_0001, 32'd0, 16'd1);
        check("lsr lit", result, 32'h3000_0000);
        check("lsr c", flags[1], 1);

        @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(4'd0, 4'd0, 1'b1, 32'd1, 32'd2, 16'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall result", result, 32'd3);
            check("stall valid", out_valid, 1);
            check("stall in_ready", in_ready, 0);
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 check("stall drain", out_valid, 0);

        for (int i = 0; i < 400; i++) begin
            logic [3:0] o, c;
            o = 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
            issue(o, c, 1'($urandom_range(0, 1)), pick(), pick(),
                  16'($urandom));
        end

        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        op = 4'd2; cond = 4'd0; s = 1'b1; a = 32'd3; b = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort flags", flags, 0);
        check("abort result", result, 0);
        @(negedge clk) rst_n = 1'b1;
        mflags = 4'b0000;
        @(negedge clk);
        check("abort in_ready", in_ready, 1);
        repeat (40) @(negedge clk);
        check("abort no result", out_valid, 0);
        issue(4'd0, 4'd0, 1'b1, 32'hFFFF_FFFF, 32'd1, 16'd0);
        check("post rst flags", flags, 4'b0110);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
